// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day counter with one alarm; advances on each rising edge of clk_sec.
// Loads take effect one edge after the strobe, ticks one edge after clk_sec is first seen high; there is no backpressure.
module time_keeper #(
    parameter int RING_SECS = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_sec,
    input  logic        time_load,
    input  logic [23:0] time_in,
    input  logic        alarm_load,
    input  logic [15:0] alarm_in,
    input  logic        alarm_en,
    input  logic        alarm_stop,
    output logic [23:0] time_out,
    output logic [15:0] alarm_time,
    output logic        sec_pulse,
    output logic        alarm_ring
);

    typedef enum logic {
        ST_IDLE,
        ST_RING
    } state_t;

    localparam logic [7:0] LP_RING_SECS = 8'(RING_SECS);

    logic        r_clk_sec_d;
    logic [23:0] r_time;
    logic [15:0] r_alarm;
    logic        r_sec_pulse;
    state_t      r_state;
    logic [7:0]  r_ring_cnt;

    logic        w_tick;
    logic        w_time_ok;
    logic        w_alarm_ok;
    logic        w_time_take;
    logic        w_adv;
    logic [23:0] w_time_inc;
    logic [7:0]  w_cnt_inc;
    state_t      w_state_nxt;
    logic [7:0]  w_ring_cnt_nxt;

    // With both digits known to be 0..9, plain binary order equals BCD order.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    assign w_tick      = clk_sec & ~r_clk_sec_d;
    assign w_time_ok   = bcd_ok(time_in[23:16], 8'h23) && bcd_ok(time_in[15:8], 8'h59)
                         && bcd_ok(time_in[7:0], 8'h59);
    assign w_alarm_ok  = bcd_ok(alarm_in[15:8], 8'h23) && bcd_ok(alarm_in[7:0], 8'h59);
    assign w_time_take = time_load & w_time_ok;
    assign w_adv       = w_tick & ~w_time_take;
    assign w_cnt_inc   = r_ring_cnt + 8'd1;

    always_comb begin
        w_time_inc = r_time;
        if (r_time[3:0] != 4'd9) begin
            w_time_inc[3:0] = r_time[3:0] + 4'd1;
        end else begin
            w_time_inc[3:0] = 4'd0;
            if (r_time[7:4] != 4'd5) begin
                w_time_inc[7:4] = r_time[7:4] + 4'd1;
            end else begin
                w_time_inc[7:4] = 4'd0;
                if (r_time[11:8] != 4'd9) begin
                    w_time_inc[11:8] = r_time[11:8] + 4'd1;
                end else begin
                    w_time_inc[11:8] = 4'd0;
                    if (r_time[15:12] != 4'd5) begin
                        w_time_inc[15:12] = r_time[15:12] + 4'd1;
                    end else begin
                        w_time_inc[15:12] = 4'd0;
                        if (r_time[23:16] == 8'h23) begin
                            w_time_inc[23:16] = 8'h00;
                        end else if (r_time[19:16] == 4'd9) begin
                            w_time_inc[19:16] = 4'd0;
                            w_time_inc[23:20] = r_time[23:20] + 4'd1;
                        end else begin
                            w_time_inc[19:16] = r_time[19:16] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Only applied ticks count; a load landing on a tick never triggers the alarm.
    always_comb begin
        w_state_nxt    = r_state;
        w_ring_cnt_nxt = r_ring_cnt;
        case (r_state)
            ST_IDLE: begin
                w_ring_cnt_nxt = 8'd0;
                if (w_adv && alarm_en && !alarm_stop && (w_time_inc == {r_alarm, 8'h00})) begin
                    w_state_nxt = ST_RING;
                end
            end
            ST_RING: begin
                if (alarm_stop || !alarm_en) begin
                    w_state_nxt    = ST_IDLE;
                    w_ring_cnt_nxt = 8'd0;
                end else if (w_adv) begin
                    if (w_cnt_inc == LP_RING_SECS) begin
                        w_state_nxt    = ST_IDLE;
                        w_ring_cnt_nxt = 8'd0;
                    end else begin
                        w_ring_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_ring_cnt_nxt = 8'd0;
            end
        endcase
    end

    // clk_sec_d tracks clk_sec through reset so release with clk_sec high is not a tick.
    always_ff @(posedge clk) begin
        r_clk_sec_d <= clk_sec;
        if (rst) begin
            r_time      <= 24'h000000;
            r_alarm     <= 16'h0000;
            r_sec_pulse <= 1'b0;
            r_state     <= ST_IDLE;
            r_ring_cnt  <= 8'd0;
        end else begin
            if (w_time_take) begin
                r_time <= time_in;
            end else if (w_adv) begin
                r_time <= w_time_inc;
            end
            if (alarm_load && w_alarm_ok) begin
                r_alarm <= alarm_in;
            end
            r_sec_pulse <= w_adv;
            r_state     <= w_state_nxt;
            r_ring_cnt  <= w_ring_cnt_nxt;
        end
    end

    assign time_out   = r_time;
    assign alarm_time = r_alarm;
    assign sec_pulse  = r_sec_pulse;
    assign alarm_ring = (r_state == ST_RING);

endmodule
